// File: rtl/fetchflare_fifo_stream_adapter.sv
// Registered-read FIFO to valid/ready stream adapter with a SKID-entry output buffer.
// Optional perf counters are enabled with FETCHFLARE_STREAM_ADAPTER_PERF_EN.
module fetchflare_fifo_stream_adapter #(
  parameter int Dw   = 160,
  parameter int SKID = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [Dw-1:0]              fifo_dout,
  input  logic                       flush,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [Dw-1:0]              m_data,
  output logic [$clog2(SKID+1)-1:0]  occupancy
`ifdef FETCHFLARE_STREAM_ADAPTER_PERF_EN
  ,
  output logic [31:0]                perf_beats,
  output logic [31:0]                perf_stalls
`endif
);

  localparam int OCC_W = $clog2(SKID + 1);
  localparam int LVL_W = OCC_W + 1;
  localparam int PTR_W = $clog2(SKID);

  logic [Dw-1:0]    mem_q [SKID];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             inflight_q, inflight_d;
  logic             pop;
  logic             capture;
  logic [LVL_W-1:0] level;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(SKID - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign pop     = m_valid & m_ready;
  assign capture = inflight_q & ~flush;

  // Entries committed after this edge: buffered plus the one in flight, minus the one leaving.
  assign level      = LVL_W'(count_q) + LVL_W'(inflight_q) - LVL_W'(pop);
  assign fifo_rd_en = reset & ~fifo_empty & ~flush & (level < LVL_W'(SKID));

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = fifo_rd_en;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)     head_d = ptr_inc(head_q);
      if (capture) tail_d = ptr_inc(tail_q);
      count_d = count_q + OCC_W'(capture) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  // Data storage carries no reset; m_valid qualifies it.
  always_ff @(posedge clk) begin
    if (capture) mem_q[tail_q] <= fifo_dout;
  end

  assign m_valid   = (count_q != '0);
  assign m_data    = mem_q[head_q];
  assign occupancy = count_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && capture && (count_q == OCC_W'(SKID))) begin
      $error("fetchflare_fifo_stream_adapter: capture into a full buffer");
      $finish;
    end
  end
`endif

`ifdef FETCHFLARE_STREAM_ADAPTER_PERF_EN
  logic [31:0] perf_beats_q;
  logic [31:0] perf_stalls_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_beats_q  <= '0;
      perf_stalls_q <= '0;
    end else if (flush) begin
      perf_beats_q  <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (pop && (perf_beats_q != '1))
        perf_beats_q <= perf_beats_q + 32'd1;
      if (m_valid && !m_ready && (perf_stalls_q != '1))
        perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_beats  = perf_beats_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_fetchflare_fifo_stream_adapter.sv
// Directed bench for fetchflare_fifo_stream_adapter with a registered-read FIFO model.
// Perf counter checks compile in when FETCHFLARE_STREAM_ADAPTER_PERF_EN is defined.
module tb_fetchflare_fifo_stream_adapter;

  localparam int Dw    = 160;
  localparam int SKID  = 2;
  localparam int OCC_W = $clog2(SKID + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [Dw-1:0]    fifo_dout;
  logic             flush = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [Dw-1:0]    m_data;
  logic [OCC_W-1:0] occupancy;
`ifdef FETCHFLARE_STREAM_ADAPTER_PERF_EN
  logic [31:0]      perf_beats;
  logic [31:0]      perf_stalls;
`endif

  logic [Dw-1:0] fmem [64];
  int            wr_ptr = 0;
  int            rd_ptr = 0;

  logic [Dw-1:0] beats [256];
  int            bcyc  [256];
  int            rcyc  [256];
  int            nb = 0, nrd = 0, cyc = 0;

  int            n_cmp = 0, n_bad = 0;
  int            nb0, nr0;

  fetchflare_fifo_stream_adapter #(.Dw(Dw), .SKID(SKID)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .occupancy  (occupancy)
`ifdef FETCHFLARE_STREAM_ADAPTER_PERF_EN
    ,
    .perf_beats (perf_beats),
    .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  // Upstream FIFO: dout registered one cycle after rd_en.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= fmem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (m_valid && m_ready && nb < 256) begin
      beats[nb] = m_data;
      bcyc[nb]  = cyc;
      nb = nb + 1;
    end
    if (fifo_rd_en && nrd < 256) begin
      rcyc[nrd] = cyc;
      nrd = nrd + 1;
    end
  end

  task automatic chk(input string tag, input logic [Dw-1:0] obs, input logic [Dw-1:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [Dw-1:0] w);
    fmem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  initial begin
    // 1: reset state, then first-beat latency
    push(Dw'(32'hA1));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", Dw'(m_valid), Dw'(0));
    chk("rst_rd_en", Dw'(fifo_rd_en), Dw'(0));
    chk("rst_occ", Dw'(occupancy), Dw'(0));
    reset = 1'b1;
    #1;
    chk("c1_rd_en", Dw'(fifo_rd_en), Dw'(1));
    tick();
    chk("c2_m_valid", Dw'(m_valid), Dw'(0));
    tick();
    chk("c3_m_valid", Dw'(m_valid), Dw'(1));
    chk("c3_m_data", m_data, Dw'(32'hA1));
    repeat (3) tick();

    // 2: back-to-back streaming of 8 words
    nb0 = nb; nr0 = nrd;
    for (int i = 1; i <= 8; i++) push(Dw'(i));
    repeat (14) tick();
    chk("s8_beats", Dw'(nb - nb0), Dw'(8));
    for (int k = 0; k < 8; k++) chk($sformatf("s8_data%0d", k), beats[nb0 + k], Dw'(k + 1));
    chk("s8_beat_span", Dw'(bcyc[nb0 + 7] - bcyc[nb0]), Dw'(7));
    chk("s8_reads", Dw'(nrd - nr0), Dw'(8));
    chk("s8_read_span", Dw'(rcyc[nr0 + 7] - rcyc[nr0]), Dw'(7));

    // 3: backpressure with 5 words queued upstream
    m_ready = 1'b0;
    nb0 = nb; nr0 = nrd;
    for (int i = 0; i < 5; i++) push(Dw'(32'h11 + i));
    repeat (6) tick();
    chk("bp_reads", Dw'(nrd - nr0), Dw'(2));
    chk("bp_occ", Dw'(occupancy), Dw'(2));
    chk("bp_rd_en", Dw'(fifo_rd_en), Dw'(0));
    chk("bp_m_valid", Dw'(m_valid), Dw'(1));
    chk("bp_m_data", m_data, Dw'(32'h11));
    repeat (3) tick();
    chk("bp_m_data_hold", m_data, Dw'(32'h11));
    m_ready = 1'b1;
    repeat (15) tick();
    chk("bp_beats", Dw'(nb - nb0), Dw'(5));
    for (int k = 0; k < 5; k++) chk($sformatf("bp_data%0d", k), beats[nb0 + k], Dw'(32'h11 + k));

    // 4: flush while a read is in flight
    m_ready = 1'b0;
    push(Dw'(32'h21));
    repeat (3) tick();
    chk("fl_occ_pre", Dw'(occupancy), Dw'(1));
    push(Dw'(32'h22));
    push(Dw'(32'h23));
    #1;
    chk("fl_rd_en_pre", Dw'(fifo_rd_en), Dw'(1));
    tick();
    nb0 = nb;
    flush = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("fl_rd_en", Dw'(fifo_rd_en), Dw'(0));
    tick();
    flush = 1'b0;
    #1;
    chk("fl_m_valid", Dw'(m_valid), Dw'(0));
    chk("fl_occ", Dw'(occupancy), Dw'(0));
    repeat (10) tick();
    chk("fl_beats", Dw'(nb - nb0), Dw'(2));
    chk("fl_data0", beats[nb0], Dw'(32'h21));
    chk("fl_data1", beats[nb0 + 1], Dw'(32'h23));

    // 5: asynchronous reset mid-stream
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(Dw'(32'h31 + i));
    repeat (5) tick();
    chk("ar_occ_pre", Dw'(occupancy), Dw'(2));
    #2;
    reset = 1'b0;
    #1;
    chk("ar_m_valid", Dw'(m_valid), Dw'(0));
    chk("ar_occ", Dw'(occupancy), Dw'(0));
    chk("ar_rd_en", Dw'(fifo_rd_en), Dw'(0));
    repeat (2) tick();
    nb0 = nb;
    reset = 1'b1;
    m_ready = 1'b1;
    repeat (10) tick();
    chk("ar_beats", Dw'(nb - nb0), Dw'(2));
    chk("ar_data0", beats[nb0], Dw'(32'h33));
    chk("ar_data1", beats[nb0 + 1], Dw'(32'h34));

`ifdef FETCHFLARE_STREAM_ADAPTER_PERF_EN
    // 6: performance counters
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("pf_beats_clr0", Dw'(perf_beats), Dw'(0));
    chk("pf_stalls_clr0", Dw'(perf_stalls), Dw'(0));
    for (int i = 0; i < 10; i++) push(Dw'(32'h41 + i));
    for (int i = 0; i < 10 && !m_valid; i++) tick();
    chk("pf_wait_valid", Dw'(m_valid), Dw'(1));
    m_ready = 1'b0;
    repeat (3) tick();
    m_ready = 1'b1;
    repeat (20) tick();
    chk("pf_beats", Dw'(perf_beats), Dw'(10));
    chk("pf_stalls", Dw'(perf_stalls), Dw'(3));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("pf_beats_clr", Dw'(perf_beats), Dw'(0));
    chk("pf_stalls_clr", Dw'(perf_stalls), Dw'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
